// File: rtl/dmem_port_ctrl.sv
`default_nettype none
// dmem_port_ctrl -- wait-stated word RAM behind the core's ext_mem port (Rev 1.0).
// Optional macro DMEM_POSTED_WRITE_EN adds a one-entry posted write buffer.
module dmem_port_ctrl #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ext_mem_addr,
  input  logic [31:0] ext_mem_wdata,
  input  logic        ext_mem_write,
  input  logic        ext_mem_read,
  output logic [31:0] ext_mem_rdata,
  output logic        ext_mem_ready,
  output logic        mem_err,
  output logic        busy
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic [31:0]             lat_wdata;
  logic                    lat_write;
  logic                    lat_illegal;

  logic [31:0]             mem [DEPTH];

  logic                    req;
  logic                    in_illegal;
  logic                    in_err;
  logic [DEPTH_LOG2-1:0]   in_idx;
  logic                    post_ok;
  logic                    may_start;
  logic                    start_norm;
  logic                    drain;

  logic                    acc_go;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [31:0]             acc_wdata;
  logic                    acc_write;
  logic                    acc_illegal;
  logic [31:0]             rd_next;

  logic                    ram_we;
  logic [DEPTH_LOG2-1:0]   ram_widx;
  logic [31:0]             ram_wdata;

  assign req        = ext_mem_read | ext_mem_write;
  assign in_illegal = (ext_mem_addr[1:0] != 2'b00) ||
                      ({1'b0, ext_mem_addr[15:2]} >= 15'(DEPTH));
  assign in_err     = in_illegal | (ext_mem_read & ext_mem_write);
  assign in_idx     = ext_mem_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_POSTED_WRITE_EN
  logic                  buf_valid;
  logic [DEPTH_LOG2-1:0] buf_idx;
  logic [31:0]           buf_data;
  logic [3:0]            buf_cnt;

  assign drain   = buf_valid && (buf_cnt == 4'd0);
  // A new post may take the slot in the same cycle the old entry drains.
  assign post_ok = (state == IDLE) && ext_mem_write && !ext_mem_read && !in_illegal &&
                   (!buf_valid || drain);
  // Only a same-word read may overlap a pending entry; everything else waits for an empty buffer.
  assign may_start = !buf_valid ||
                     (ext_mem_read && !ext_mem_write && !in_illegal && (buf_idx == in_idx));
  assign busy      = (state != IDLE) || buf_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
      buf_cnt   <= 4'd0;
    end else if (post_ok) begin
      buf_valid <= 1'b1;
      buf_idx   <= in_idx;
      buf_data  <= ext_mem_wdata;
      buf_cnt   <= 4'(WAIT_CYCLES);
    end else if (drain) begin
      buf_valid <= 1'b0;
    end else if (buf_valid) begin
      buf_cnt <= buf_cnt - 4'd1;
    end
  end
`else
  assign drain     = 1'b0;
  assign post_ok   = 1'b0;
  assign may_start = 1'b1;
  assign busy      = (state != IDLE);
`endif

  assign start_norm = (state == IDLE) && req && may_start && !post_ok;

  // With zero wait states the access happens on the accepting edge, so use live inputs.
  always_comb begin
    acc_go      = 1'b0;
    acc_idx     = lat_idx;
    acc_wdata   = lat_wdata;
    acc_write   = lat_write;
    acc_illegal = lat_illegal;
    if (state == IDLE) begin
      acc_idx     = in_idx;
      acc_wdata   = ext_mem_wdata;
      acc_write   = ext_mem_write;
      acc_illegal = in_illegal;
      acc_go      = (WAIT_CYCLES == 0) && start_norm;
    end else if (state == WAIT) begin
      acc_go = (cnt == 4'd0);
    end
  end

  always_comb begin
    rd_next = mem[acc_idx];
`ifdef DMEM_POSTED_WRITE_EN
    if (buf_valid && (buf_idx == acc_idx)) rd_next = buf_data;
`endif
    if (acc_illegal) rd_next = '0;
  end

  always_comb begin
    ram_we    = acc_go && acc_write && !acc_illegal;
    ram_widx  = acc_idx;
    ram_wdata = acc_wdata;
`ifdef DMEM_POSTED_WRITE_EN
    if (drain) begin
      ram_we    = 1'b1;
      ram_widx  = buf_idx;
      ram_wdata = buf_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_widx] <= ram_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      lat_idx       <= '0;
      lat_wdata     <= '0;
      lat_write     <= 1'b0;
      lat_illegal   <= 1'b0;
      ext_mem_ready <= 1'b0;
      ext_mem_rdata <= '0;
      mem_err       <= 1'b0;
    end else begin
      ext_mem_ready <= 1'b0;
      if (acc_go && !acc_write) ext_mem_rdata <= rd_next;
      case (state)
        IDLE: begin
          if (post_ok) begin
            ext_mem_ready <= 1'b1;
            state         <= ACCESS;
          end else if (start_norm) begin
            lat_idx     <= in_idx;
            lat_wdata   <= ext_mem_wdata;
            lat_write   <= ext_mem_write;
            lat_illegal <= in_illegal;
            mem_err     <= mem_err | in_err;
            if (WAIT_CYCLES == 0) begin
              ext_mem_ready <= 1'b1;
              state         <= ACCESS;
            end else begin
              cnt   <= WAIT_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            ext_mem_ready <= 1'b1;
            state         <= ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACCESS:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_ctrl.sv
`default_nettype none
// tb_dmem_port_ctrl -- directed bench driving three instances (WAIT_CYCLES 2, 0, 3).
module tb_dmem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr  [3];
  logic [31:0] wdata [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        err   [3];
  logic        busy  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    dmem_port_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(W)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .ext_mem_addr (addr[g]),
      .ext_mem_wdata(wdata[g]),
      .ext_mem_write(wr[g]),
      .ext_mem_read (rd[g]),
      .ext_mem_rdata(rdata[g]),
      .ext_mem_ready(ready[g]),
      .mem_err      (err[g]),
      .busy         (busy[g])
    );
  end

  function automatic int wlat(input int k);
    int w;
    w = (k == 0) ? 2 : ((k == 1) ? 0 : 3);
`ifdef DMEM_POSTED_WRITE_EN
    return 1;
`else
    return w + 1;
`endif
  endfunction

  // Drive one request (called #1 after a rising edge); returns latency in cycles or -1 on timeout.
  task automatic do_access(input int k, input logic r, input logic w, input logic [15:0] a,
                           input logic [31:0] d, output int lat, output logic [31:0] data,
                           output logic e, output logic b);
    rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d;
    lat = -1; data = 'x; e = 1'bx; b = 1'bx;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready[k] === 1'b1) begin
        lat = n; data = rdata[k]; e = err[k]; b = busy[k];
        break;
      end
    end
    @(posedge clk); #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy[k] === 1'b0) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin rd[k] = 0; wr[k] = 0; addr[k] = 0; wdata[k] = 0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++; if (ready[k] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got=%b exp=0", k, ready[k]); end
      total++; if (rdata[k] !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d] got=%h exp=0", k, rdata[k]); end
      total++; if (err[k] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] got=%b exp=0", k, err[k]); end
      total++; if (busy[k] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b exp=0", k, busy[k]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] d; logic e, b;
    do_access(0, 0, 1, 16'h0010, 32'hCAFE_BABE, lat, d, e, b);
    total++; if (lat != wlat(0)) begin bad++; $display("FAIL basic_wr_lat got=%0d exp=%0d", lat, wlat(0)); end
    do_access(0, 1, 0, 16'h0010, 32'h0, lat, d, e, b);
    total++; if (lat != 3) begin bad++; $display("FAIL basic_rd_lat got=%0d exp=3", lat); end
    total++; if (d !== 32'hCAFE_BABE) begin bad++; $display("FAIL basic_rd_data got=%h exp=cafebabe", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", e); end
    do_access(0, 0, 1, 16'h0014, 32'h0000_0000, lat, d, e, b);
    total++; if (d !== 32'hCAFE_BABE) begin bad++; $display("FAIL basic_rdata_hold got=%h exp=cafebabe", d); end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] d; logic e, b; logic ok;
    wait_idle(0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL illegal_idle_timeout got=%b exp=1", ok); end
    do_access(0, 1, 0, 16'h0013, 32'h0, lat, d, e, b);
    total++; if (lat != 3) begin bad++; $display("FAIL illegal_lat got=%0d exp=3", lat); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL illegal_rdata got=%h exp=0", d); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", e); end
    do_access(0, 1, 0, 16'h0010, 32'h0, lat, d, e, b);
    total++; if (d !== 32'hCAFE_BABE) begin bad++; $display("FAIL illegal_after_data got=%h exp=cafebabe", d); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL illegal_sticky got=%b exp=1", e); end
  endtask

  task automatic test_rw_both();
    int lat; logic [31:0] d; logic e, b;
    total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL rw_err_cleared got=%b exp=0", err[0]); end
    do_access(0, 1, 1, 16'h0004, 32'h1234_5678, lat, d, e, b);
    total++; if (lat != 3) begin bad++; $display("FAIL rw_lat got=%0d exp=3", lat); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL rw_err got=%b exp=1", e); end
    do_access(0, 1, 0, 16'h0004, 32'h0, lat, d, e, b);
    total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL rw_readback got=%h exp=12345678", d); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic e, b; time t0;
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      do_access(1, 0, 1, 16'(i * 4), 32'(i), lat, d, e, b);
      total++; if (lat != 1) begin bad++; $display("FAIL b2b_wr_lat[%0d] got=%0d exp=1", i, lat); end
    end
    for (int i = 0; i < 8; i++) begin
      do_access(1, 1, 0, 16'(i * 4), 32'h0, lat, d, e, b);
      total++; if (lat != 1) begin bad++; $display("FAIL b2b_rd_lat[%0d] got=%0d exp=1", i, lat); end
      total++; if (d !== 32'(i)) begin bad++; $display("FAIL b2b_rd_data[%0d] got=%h exp=%h", i, d, 32'(i)); end
    end
    total++; if ($time - t0 != 320) begin bad++; $display("FAIL b2b_elapsed got=%0t exp=320", $time - t0); end
    total++; if (err[1] !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b exp=0", err[1]); end
    do_access(1, 0, 1, 16'h1000, 32'hFFFF_FFFF, lat, d, e, b);
    total++; if (lat != 1) begin bad++; $display("FAIL oob_lat got=%0d exp=1", lat); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oob_err got=%b exp=1", e); end
    do_access(1, 1, 0, 16'h0000, 32'h0, lat, d, e, b);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL oob_no_alias got=%h exp=0", d); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] d; logic e, b; logic ok;
    do_access(0, 0, 1, 16'h0020, 32'h0000_7777, lat, d, e, b);
    wait_idle(0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rstmid_idle_timeout got=%b exp=1", ok); end
    wr[0] = 1'b1; addr[0] = 16'h0020; wdata[0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (ready[0] !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b exp=0", ready[0]); end
    total++; if (rdata[0] !== 32'h0) begin bad++; $display("FAIL rstmid_rdata got=%h exp=0", rdata[0]); end
    total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b exp=0", err[0]); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy[0]); end
    wr[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    do_access(0, 1, 0, 16'h0020, 32'h0, lat, d, e, b);
    total++; if (d !== 32'h0000_7777) begin bad++; $display("FAIL rstmid_dropped got=%h exp=00007777", d); end
  endtask

  task automatic test_posted();
    int lat; logic [31:0] d; logic e, b; logic ok; int nb;
`ifdef DMEM_POSTED_WRITE_EN
    do_access(2, 0, 1, 16'h0044, 32'h0BAD_F00D, lat, d, e, b);
    wait_idle(2, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL post_idle_timeout got=%b exp=1", ok); end
    do_access(2, 0, 1, 16'h0040, 32'hA5A5_A5A5, lat, d, e, b);
    total++; if (lat != 1) begin bad++; $display("FAIL post_wr_lat got=%0d exp=1", lat); end
    nb = (b === 1'b1) ? 1 : 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy[2] === 1'b1) nb++; else break;
    end
    total++; if (nb != 4) begin bad++; $display("FAIL post_busy_cycles got=%0d exp=4", nb); end
    @(posedge clk); #1;
    do_access(2, 1, 0, 16'h0040, 32'h0, lat, d, e, b);
    total++; if (d !== 32'hA5A5_A5A5) begin bad++; $display("FAIL post_drained_data got=%h exp=a5a5a5a5", d); end
    do_access(2, 0, 1, 16'h0040, 32'h5A5A_5A5A, lat, d, e, b);
    do_access(2, 1, 0, 16'h0040, 32'h0, lat, d, e, b);
    total++; if (lat != 4) begin bad++; $display("FAIL post_fwd_lat got=%0d exp=4", lat); end
    total++; if (d !== 32'h5A5A_5A5A) begin bad++; $display("FAIL post_fwd_data got=%h exp=5a5a5a5a", d); end
    do_access(2, 0, 1, 16'h0040, 32'h1111_2222, lat, d, e, b);
    do_access(2, 1, 0, 16'h0044, 32'h0, lat, d, e, b);
    total++; if (lat != 7) begin bad++; $display("FAIL post_other_lat got=%0d exp=7", lat); end
    total++; if (d !== 32'h0BAD_F00D) begin bad++; $display("FAIL post_other_data got=%h exp=0badf00d", d); end
`else
    ok = 1'b1; nb = 0;
    do_access(2, 0, 1, 16'h0040, 32'hA5A5_A5A5, lat, d, e, b);
    total++; if (lat != 4) begin bad++; $display("FAIL w3_wr_lat got=%0d exp=4", lat); end
    total++; if (b !== 1'b1) begin bad++; $display("FAIL w3_busy got=%b exp=1", b); end
    do_access(2, 1, 0, 16'h0040, 32'h0, lat, d, e, b);
    total++; if (lat != 4) begin bad++; $display("FAIL w3_rd_lat got=%0d exp=4", lat); end
    total++; if (d !== 32'hA5A5_A5A5) begin bad++; $display("FAIL w3_rd_data got=%h exp=a5a5a5a5", d); end
`endif
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_illegal();
    do_reset();
    test_rw_both();
    test_back_to_back();
    test_reset_mid();
    test_posted();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
